// File: rtl/universal_register_n_if.sv
// Control, load-data and status bundle for universal_register_n.
// master drives the controls; slave is the register itself.
interface universal_register_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cl;
    logic             ld;
    logic [WIDTH-1:0] in;
    logic             inc;
    logic             dec;
    logic             sr;
    logic             ir;
    logic             sl;
    logic             il;
    logic             rot;
    logic             asr;
    logic             go;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] out;
    logic             cy;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output cl, ld, in, inc, dec, sr, ir, sl, il, rot, asr, go, cnt,
        input  out, cy, zero, busy, done
    );

    modport slave (
        input  cl, ld, in, inc, dec, sr, ir, sl, il, rot, asr, go, cnt,
        output out, cy, zero, busy, done
    );
endinterface

// File: rtl/universal_register_n.sv
// WIDTH-bit universal register: clear/load/inc/dec/shift/rotate plus a shift-by-N sequencer.
// Define SATURATE_EN to make inc/dec saturate at all-ones / zero instead of wrapping.
module universal_register_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    universal_register_n_if.slave   bus
);
    // state | meaning
    // IDLE  | single-cycle ops decoded by priority; go may start a multi-cycle shift
    // SHIFT | one captured-mode shift step per edge until the remaining count hits 0
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_out, w_out_nxt;
    logic             r_cy, w_cy_nxt;
    logic [CNT_W-1:0] r_rem, w_rem_nxt;
    logic             r_done, w_done_nxt;
    logic             r_right, w_right_nxt;
    logic             r_rot, w_rot_nxt;
    logic             r_asr, w_asr_nxt;
    logic             r_ir, w_ir_nxt;
    logic             r_il, w_il_nxt;

    // Returns {bit shifted out, new value}; rot overrides asr and the serial fill bits.
    function automatic logic [WIDTH:0] f_step(
        input logic [WIDTH-1:0] v,
        input logic             right,
        input logic             rot,
        input logic             asr,
        input logic             ir,
        input logic             il
    );
        logic fill;
        if (right) begin
            fill = rot ? v[0] : (asr ? v[WIDTH-1] : ir);
            return {v[0], fill, v[WIDTH-1:1]};
        end
        fill = rot ? v[WIDTH-1] : il;
        return {v[WIDTH-1], v[WIDTH-2:0], fill};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_cy    <= 1'b0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_right <= 1'b0;
            r_rot   <= 1'b0;
            r_asr   <= 1'b0;
            r_ir    <= 1'b0;
            r_il    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_cy    <= w_cy_nxt;
            r_rem   <= w_rem_nxt;
            r_done  <= w_done_nxt;
            r_right <= w_right_nxt;
            r_rot   <= w_rot_nxt;
            r_asr   <= w_asr_nxt;
            r_ir    <= w_ir_nxt;
            r_il    <= w_il_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_cy_nxt    = r_cy;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;
        w_right_nxt = r_right;
        w_rot_nxt   = r_rot;
        w_asr_nxt   = r_asr;
        w_ir_nxt    = r_ir;
        w_il_nxt    = r_il;
        case (r_state)
            IDLE: begin
                if (bus.cl) begin
                    w_out_nxt = '0;
                    w_cy_nxt  = 1'b0;
                end else if (bus.ld) begin
                    w_out_nxt = bus.in;
                    w_cy_nxt  = 1'b0;
                end else if (bus.inc) begin
                    {w_cy_nxt, w_out_nxt} = {1'b0, r_out} + (WIDTH+1)'(1);
`ifdef SATURATE_EN
                    if (&r_out) w_out_nxt = r_out;
`endif
                end else if (bus.dec) begin
                    w_cy_nxt  = (r_out == '0);
                    w_out_nxt = r_out - WIDTH'(1);
`ifdef SATURATE_EN
                    if (r_out == '0) w_out_nxt = r_out;
`endif
                end else if (bus.go && (bus.sr || bus.sl)) begin
                    w_right_nxt = bus.sr;
                    w_rot_nxt   = bus.rot;
                    w_asr_nxt   = bus.asr;
                    w_ir_nxt    = bus.ir;
                    w_il_nxt    = bus.il;
                    w_rem_nxt   = bus.cnt;
                    if (bus.cnt != '0) w_state_nxt = SHIFT;
                    else               w_done_nxt  = 1'b1;
                end else if (bus.sr) begin
                    {w_cy_nxt, w_out_nxt} = f_step(r_out, 1'b1, bus.rot, bus.asr, bus.ir, bus.il);
                end else if (bus.sl) begin
                    {w_cy_nxt, w_out_nxt} = f_step(r_out, 1'b0, bus.rot, bus.asr, bus.ir, bus.il);
                end
            end
            SHIFT: begin
                // Clear aborts the sequence without a done pulse.
                if (bus.cl) begin
                    w_out_nxt   = '0;
                    w_cy_nxt    = 1'b0;
                    w_rem_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    {w_cy_nxt, w_out_nxt} = f_step(r_out, r_right, r_rot, r_asr, r_ir, r_il);
                    w_rem_nxt = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.out  = r_out;
    assign bus.cy   = r_cy;
    assign bus.zero = (r_out == '0);
    assign bus.busy = (r_state == SHIFT);
    assign bus.done = r_done;
endmodule

// File: tb/tb_universal_register_n.sv
// Bench for universal_register_n (WIDTH=8): directed vector table, multi-cycle sequences,
// and randomized traffic against an arithmetic reference model.
module tb_universal_register_n;
    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MOD  = 2 ** W;
    localparam int HALF = 2 ** (W - 1);
`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
    localparam logic [7:0] INC_FF = 8'hFF;
    localparam logic [7:0] DEC_00 = 8'h00;
`else
    localparam bit SAT = 1'b0;
    localparam logic [7:0] INC_FF = 8'h00;
    localparam logic [7:0] DEC_00 = 8'hFF;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    universal_register_n_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    universal_register_n #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int m_out, m_cy, m_busy, m_done, m_rem;
    int c_right, c_rot, c_asr, c_ir, c_il;

    typedef struct {
        logic       cl, ld;
        logic [7:0] in;
        logic       inc, dec, sr, ir, sl, il, rot, asr;
        logic [7:0] e_out;
        logic       e_cy;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.cl = 0; bus.ld = 0; bus.in = '0; bus.inc = 0; bus.dec = 0;
        bus.sr = 0; bus.ir = 0; bus.sl = 0; bus.il = 0; bus.rot = 0; bus.asr = 0;
        bus.go = 0; bus.cnt = '0;
    endtask

    task automatic model_reset();
        m_out = 0; m_cy = 0; m_busy = 0; m_done = 0; m_rem = 0;
        c_right = 0; c_rot = 0; c_asr = 0; c_ir = 0; c_il = 0;
    endtask

    task automatic do_shift(input int right, input int rot, input int asr, input int ir, input int il);
        int fill;
        if (right != 0) begin
            fill  = (rot != 0) ? m_out % 2 : ((asr != 0) ? m_out / HALF : ir);
            m_cy  = m_out % 2;
            m_out = m_out / 2 + fill * HALF;
        end else begin
            fill  = (rot != 0) ? m_out / HALF : il;
            m_cy  = m_out / HALF;
            m_out = (m_out * 2) % MOD + fill;
        end
    endtask

    task automatic model_edge();
        int nd;
        nd = 0;
        if (m_busy == 0) begin
            if (bus.cl) begin
                m_out = 0; m_cy = 0;
            end else if (bus.ld) begin
                m_out = int'(bus.in); m_cy = 0;
            end else if (bus.inc) begin
                if (m_out == MOD - 1) begin m_cy = 1; m_out = SAT ? MOD - 1 : 0; end
                else begin m_out = m_out + 1; m_cy = 0; end
            end else if (bus.dec) begin
                if (m_out == 0) begin m_cy = 1; m_out = SAT ? 0 : MOD - 1; end
                else begin m_out = m_out - 1; m_cy = 0; end
            end else if (bus.go && (bus.sr || bus.sl)) begin
                c_right = int'(bus.sr); c_rot = int'(bus.rot); c_asr = int'(bus.asr);
                c_ir = int'(bus.ir); c_il = int'(bus.il);
                m_rem = int'(bus.cnt);
                if (m_rem == 0) nd = 1;
                else m_busy = 1;
            end else if (bus.sr) begin
                do_shift(1, int'(bus.rot), int'(bus.asr), int'(bus.ir), int'(bus.il));
            end else if (bus.sl) begin
                do_shift(0, int'(bus.rot), int'(bus.asr), int'(bus.ir), int'(bus.il));
            end
        end else begin
            if (bus.cl) begin
                m_out = 0; m_cy = 0; m_busy = 0; m_rem = 0;
            end else begin
                do_shift(c_right, c_rot, c_asr, c_ir, c_il);
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_busy = 0; nd = 1; end
            end
        end
        m_done = nd;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out"},  bus.out,  m_out);
        chk({tag, ".cy"},   bus.cy,   m_cy);
        chk({tag, ".zero"}, bus.zero, (m_out == 0));
        chk({tag, ".busy"}, bus.busy, m_busy);
        chk({tag, ".done"}, bus.done, m_done);
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic add_vec(input logic cl, ld, input logic [7:0] in, input logic inc, dec, sr, ir,
                           sl, il, rot, asr, input logic [7:0] e_out, input logic e_cy);
        vec_t v;
        v = '{cl, ld, in, inc, dec, sr, ir, sl, il, rot, asr, e_out, e_cy};
        tv.push_back(v);
    endtask

    initial begin
        //        cl ld in     inc dec sr ir sl il rot asr  out     cy
        add_vec(0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0,  8'hFF,  0);
        add_vec(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0,  INC_FF, 1);
        add_vec(0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  8'h00,  0);
        add_vec(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0,  DEC_00, 1);
        add_vec(0, 1, 8'h81, 0, 0, 0, 0, 0, 0, 0, 0,  8'h81,  0);
        add_vec(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 1,  8'hC0,  1);
        add_vec(0, 1, 8'h81, 0, 0, 0, 0, 0, 0, 0, 0,  8'h81,  0);
        add_vec(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 0,  8'hC0,  1);
        add_vec(0, 1, 8'h81, 0, 0, 0, 0, 0, 0, 0, 0,  8'h81,  0);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0,  8'h03,  1);
        add_vec(0, 1, 8'h81, 0, 0, 0, 0, 0, 0, 0, 0,  8'h81,  0);
        add_vec(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0,  8'h40,  1);
        add_vec(0, 1, 8'h81, 0, 0, 0, 0, 0, 0, 0, 0,  8'h81,  0);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0,  8'h03,  1);
        add_vec(0, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 0,  8'h81,  1);
        add_vec(1, 1, 8'h55, 0, 0, 0, 0, 0, 0, 0, 0,  8'h00,  0);
        add_vec(0, 1, 8'h55, 1, 0, 0, 0, 0, 0, 0, 0,  8'h55,  0);
        add_vec(0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0,  8'h56,  0);
        add_vec(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  8'h56,  0);
        add_vec(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 1,  8'h2B,  0);
        add_vec(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0,  8'h2A,  0);

        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        #12;
        chk("reset.out", bus.out, 0);
        chk("reset.cy", bus.cy, 0);
        chk("reset.zero", bus.zero, 1);
        chk("reset.busy", bus.busy, 0);
        chk("reset.done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            clear_inputs();
            bus.cl = tv[i].cl; bus.ld = tv[i].ld; bus.in = tv[i].in;
            bus.inc = tv[i].inc; bus.dec = tv[i].dec; bus.sr = tv[i].sr; bus.ir = tv[i].ir;
            bus.sl = tv[i].sl; bus.il = tv[i].il; bus.rot = tv[i].rot; bus.asr = tv[i].asr;
            model_edge();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.out", i), bus.out, tv[i].e_out);
            chk($sformatf("vec%0d.cy", i), bus.cy, tv[i].e_cy);
            chk($sformatf("vec%0d.zero", i), bus.zero, (tv[i].e_out == 8'h00));
        end

        // go+sl cnt=3 from 0x01
        clear_inputs(); bus.ld = 1; bus.in = 8'h01; tick("g3.ld");
        clear_inputs(); bus.go = 1; bus.sl = 1; bus.cnt = 4'd3; tick("g3.acc");
        chk("g3.busy1", bus.busy, 1);
        clear_inputs(); tick("g3.s1"); chk("g3.out1", bus.out, 8'h02);
        tick("g3.s2"); chk("g3.out2", bus.out, 8'h04); chk("g3.busy3", bus.busy, 1);
        tick("g3.s3"); chk("g3.out3", bus.out, 8'h08);
        chk("g3.done", bus.done, 1); chk("g3.busy_end", bus.busy, 0);
        tick("g3.after"); chk("g3.done_pulse", bus.done, 0);

        // rotate right by 4 from 0x96, with junk controls while busy
        bus.ld = 1; bus.in = 8'h96; tick("r4.ld");
        clear_inputs(); bus.go = 1; bus.sr = 1; bus.rot = 1; bus.cnt = 4'd4; tick("r4.acc");
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            bus.ld = 1; bus.in = 8'h00; bus.inc = 1; bus.rot = k[0]; bus.sl = 1;
            bus.go = 1; bus.cnt = 4'd1; bus.ir = 1;
            tick("r4.busy");
        end
        clear_inputs(); tick("r4.end");
        chk("r4.out", bus.out, 8'h69); chk("r4.done", bus.done, 1);

        // abort: go+sl cnt=5, cl on the 2nd busy cycle
        bus.ld = 1; bus.in = 8'h01; tick("ab.ld");
        clear_inputs(); bus.go = 1; bus.sl = 1; bus.cnt = 4'd5; tick("ab.acc");
        clear_inputs(); tick("ab.s1");
        bus.cl = 1; tick("ab.cl");
        chk("ab.out", bus.out, 0); chk("ab.busy", bus.busy, 0); chk("ab.nodone", bus.done, 0);
        clear_inputs(); tick("ab.after"); chk("ab.nodone2", bus.done, 0);

        // zero-count go, then a go accepted while done is high
        bus.ld = 1; bus.in = 8'h3C; tick("z0.ld");
        clear_inputs(); bus.go = 1; bus.sr = 1; bus.cnt = 4'd0; tick("z0.acc");
        chk("z0.out", bus.out, 8'h3C); chk("z0.busy", bus.busy, 0); chk("z0.done", bus.done, 1);
        clear_inputs(); bus.go = 1; bus.sl = 1; bus.cnt = 4'd2; tick("z0.go2");
        chk("z0.busy2", bus.busy, 1); chk("z0.done2", bus.done, 0);
        clear_inputs(); tick("z0.s1"); tick("z0.s2");
        chk("z0.out2", bus.out, 8'hF0); chk("z0.done3", bus.done, 1);

        // asynchronous reset mid-shift
        bus.ld = 1; bus.in = 8'hA5; tick("rs.ld");
        clear_inputs(); bus.go = 1; bus.sr = 1; bus.cnt = 4'd6; tick("rs.acc");
        clear_inputs(); tick("rs.s1");
        chk("rs.cy_pre", bus.cy, 1);
        #2; rst_n = 1'b0; #1;
        chk("rs.out", bus.out, 0); chk("rs.cy", bus.cy, 0);
        chk("rs.busy", bus.busy, 0); chk("rs.done", bus.done, 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        tick("rs.after");

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            bus.cl  = ($urandom_range(0, 39) == 0);
            bus.ld  = ($urandom_range(0, 7) == 0);
            bus.in  = 8'($urandom);
            bus.inc = ($urandom_range(0, 7) == 0);
            bus.dec = ($urandom_range(0, 7) == 0);
            bus.sr  = $urandom_range(0, 1) == 1;
            bus.sl  = $urandom_range(0, 1) == 1;
            bus.ir  = $urandom_range(0, 1) == 1;
            bus.il  = $urandom_range(0, 1) == 1;
            bus.rot = ($urandom_range(0, 2) == 0);
            bus.asr = ($urandom_range(0, 2) == 0);
            bus.go  = ($urandom_range(0, 5) == 0);
            bus.cnt = 4'($urandom_range(0, 15));
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
